bcd_switch_counter: RTL and testbench



---
 rtl/bcd_pkg.sv | 32 +++
 rtl/bcd_digit.sv | 33 +++
 rtl/bcd_switch_counter.sv | 79 +++++++
 tb/tb_bcd_switch_counter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types, constants and switch-priority decode for the three-digit BCD counter.
package bcd_pkg;

    typedef logic [3:0]  bcd_digit_t;
    typedef logic [11:0] bcd3_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
    localparam bcd3_t      BCD_ZERO      = 12'h000;
    localparam int         BCD_DIGITS    = 3;

    typedef enum logic [1:0] {
        HOLD,
        UP,
        DOWN
    } step_dir_t;

    // Hold beats everything; both directions at once is a conflict and also holds.
    function automatic step_dir_t decode_dir(input logic up_sw, input logic dn_sw,
                                             input logic hold_sw);
        if (hold_sw)
            return HOLD;
        else if (up_sw && dn_sw)
            return HOLD;
        else if (up_sw)
            return UP;
        else if (dn_sw)
            return DOWN;
        else
            return HOLD;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register: steps up or down when enabled with an incoming carry/borrow,
// and reports a carry/borrow out when it wraps 9->0 or 0->9.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       cin,
    output bcd_digit_t q,
    output logic       cout
);

    bcd_digit_t r_q;
    logic       w_at_limit;

    assign w_at_limit = up ? (r_q == BCD_MAX_DIGIT) : (r_q == 4'd0);
    assign cout       = en & cin & w_at_limit;
    assign q          = r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= BCD_ZERO[3:0];
        end else if (en && cin) begin
            if (w_at_limit)
                r_q <= up ? 4'd0 : BCD_MAX_DIGIT;
            else
                r_q <= up ? (r_q + 4'd1) : (r_q - 4'd1);
        end
    end

endmodule

// File: rtl/bcd_switch_counter.sv
// Three-digit packed-BCD up/down counter (000-999) driven by four static switches,
// with a free-running prescaler that sets how often a step may occur.
module bcd_switch_counter
    import bcd_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SWITCH1,
    input  logic        SWITCH2,
    input  logic        SWITCH3,
    input  logic        SWITCH4,
    output logic [11:0] dec_out
);

    logic w_tick;

    generate
        if (TICK_DIV > 1) begin : g_presc
            localparam int PW = $clog2(TICK_DIV);
            logic [PW-1:0] r_presc;

            assign w_tick = (r_presc == PW'(TICK_DIV - 1));

            always_ff @(posedge clk) begin
                if (rst)
                    r_presc <= '0;
                else if (w_tick)
                    r_presc <= '0;
                else
                    r_presc <= r_presc + PW'(1);
            end
        end else begin : g_no_presc
            assign w_tick = 1'b1;
        end
    endgenerate

    step_dir_t w_dir;
    logic      w_step;
    logic      w_up;

    assign w_dir  = decode_dir(SWITCH1, SWITCH2, SWITCH4);
    assign w_step = w_tick && (w_dir != HOLD);
    assign w_up   = (w_dir == UP);

    logic [BCD_DIGITS-1:0] w_en;
    logic [BCD_DIGITS-1:0] w_cin;
    logic [BCD_DIGITS-1:0] w_cout;
    bcd_digit_t            w_q [BCD_DIGITS];
    logic                  w_unused_wrap;

    // A +/-10 step leaves the ones digit alone and injects the unit step at the tens digit.
    assign w_en[0]  = w_step & ~SWITCH3;
    assign w_cin[0] = 1'b1;
    assign w_en[1]  = w_step;
    assign w_cin[1] = SWITCH3 ? 1'b1 : w_cout[0];
    assign w_en[2]  = w_step;
    assign w_cin[2] = w_cout[1];

    // Carry out of the hundreds digit is the modulo-1000 wrap and is simply dropped.
    assign w_unused_wrap = w_cout[BCD_DIGITS-1];

    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
            bcd_digit u_digit (
                .clk  (clk),
                .rst  (rst),
                .en   (w_en[gi]),
                .up   (w_up),
                .cin  (w_cin[gi]),
                .q    (w_q[gi]),
                .cout (w_cout[gi])
            );
            assign dec_out[gi*4 +: 4] = w_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_bcd_switch_counter.sv
// Directed and randomized checks of bcd_switch_counter (TICK_DIV=1 and TICK_DIV=4)
// against an integer model of the counting rules.
module tb_bcd_switch_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rst4 = 1'b0;
    logic        SWITCH1 = 1'b0;
    logic        SWITCH2 = 1'b0;
    logic        SWITCH3 = 1'b0;
    logic        SWITCH4 = 1'b0;
    logic [11:0] dec_out;
    logic [11:0] dec_out4;

    int total  = 0;
    int passed = 0;

    // Model state: plain decimal values and prescaler count.
    int m1 = 0;
    int m4 = 0;
    int p4 = 0;

    always #5 clk = ~clk;

    bcd_switch_counter dut (
        .clk     (clk),
        .rst     (rst),
        .SWITCH1 (SWITCH1),
        .SWITCH2 (SWITCH2),
        .SWITCH3 (SWITCH3),
        .SWITCH4 (SWITCH4),
        .dec_out (dec_out)
    );

    bcd_switch_counter #(.TICK_DIV(4)) dut4 (
        .clk     (clk),
        .rst     (rst4),
        .SWITCH1 (SWITCH1),
        .SWITCH2 (SWITCH2),
        .SWITCH3 (SWITCH3),
        .SWITCH4 (SWITCH4),
        .dec_out (dec_out4)
    );

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    function automatic int next_val(input int v);
        int st;
        st = SWITCH3 ? 10 : 1;
        if (SWITCH4)                 return v;
        else if (SWITCH1 && SWITCH2) return v;
        else if (SWITCH1)            return (v + st) % 1000;
        else if (SWITCH2)            return (v + 1000 - st) % 1000;
        else                         return v;
    endfunction

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            if (rst) m1 = 0;
            else     m1 = next_val(m1);
            if (rst4) begin
                m4 = 0;
                p4 = 0;
            end else begin
                if (p4 == 3) m4 = next_val(m4);
                p4 = (p4 + 1) % 4;
            end
        end
        #1;
    endtask

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total++;
        $display("check %-12s obs=%h exp=%h", tag, obs, exp);
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_sw(input logic s1, input logic s2, input logic s3, input logic s4);
        SWITCH1 = s1;
        SWITCH2 = s2;
        SWITCH3 = s3;
        SWITCH4 = s4;
    endtask

    initial begin
        // Reset overrides all switches
        set_sw(1, 1, 1, 1);
        rst = 1; rst4 = 1;
        run(3);
        check("rst_d1", dec_out, 12'h000);
        check("rst_d4", dec_out4, 12'h000);

        rst = 0; rst4 = 0;
        set_sw(1, 0, 0, 0);
        run(12);
        check("up12_d1", dec_out, 12'h012);
        check("up12_d4", dec_out4, 12'h003);
        run(4);
        check("up16_d1", dec_out, 12'h016);
        check("up16_d4", dec_out4, 12'h004);

        // Wrap through 999
        set_sw(0, 0, 0, 0);
        rst = 1; run(1); rst = 0;
        set_sw(1, 0, 0, 0);
        run(998);
        check("load998", dec_out, 12'h998);
        run(2);
        check("wrap_up", dec_out, 12'h000);

        set_sw(0, 1, 0, 0);
        run(1);
        check("wrap_dn", dec_out, 12'h999);
        run(3);
        check("dn3", dec_out, 12'h996);
        run(1);
        check("dn995", dec_out, 12'h995);

        set_sw(1, 0, 1, 0);
        run(1);
        check("up10_wrap", dec_out, 12'h005);
        set_sw(0, 1, 1, 0);
        run(1);
        check("dn10_wrap", dec_out, 12'h995);

        set_sw(1, 0, 0, 1);
        run(10);
        check("hold_up", dec_out, 12'h995);
        set_sw(0, 1, 1, 1);
        run(3);
        check("hold_dn", dec_out, 12'h995);
        set_sw(1, 1, 0, 0);
        run(5);
        check("conflict", dec_out, 12'h995);
        set_sw(0, 0, 1, 0);
        run(2);
        check("idle", dec_out, 12'h995);

        set_sw(0, 0, 0, 0);
        rst = 1; run(1); rst = 0;
        set_sw(1, 0, 0, 0);
        run(3);
        check("up3", dec_out, 12'h003);
        set_sw(0, 1, 1, 0);
        run(1);
        check("dn10_003", dec_out, 12'h993);

        // Prescaled instance: reset in mid-count restarts the prescaler
        set_sw(1, 0, 0, 0);
        rst4 = 1; run(1); rst4 = 0;
        check("d4_rst", dec_out4, 12'h000);
        run(16);
        check("d4_up16", dec_out4, 12'h004);
        rst4 = 1; run(1); rst4 = 0;
        run(9);
        check("d4_up9", dec_out4, 12'h002);
        rst4 = 1; run(1); rst4 = 0;
        check("d4_rst10", dec_out4, 12'h000);
        run(3);
        check("d4_pre3", dec_out4, 12'h000);
        run(1);
        check("d4_pre4", dec_out4, 12'h001);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            SWITCH1 = 1'($urandom_range(0, 1));
            SWITCH2 = 1'($urandom_range(0, 1));
            SWITCH3 = 1'($urandom_range(0, 1));
            SWITCH4 = ($urandom_range(0, 7) == 0);
            rst     = ($urandom_range(0, 31) == 0);
            rst4    = ($urandom_range(0, 39) == 0);
            run(1);
            check("rnd_d1", dec_out, to_bcd(m1));
            check("rnd_d4", dec_out4, to_bcd(m4));
        end
        rst = 0; rst4 = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
